// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - frame-synchronous VGA test-pattern engine with pipeline-aligned syncs
//
// Takes the raw 25 MHz H/V counter values and raw syncs and produces registered sync
// and 4-bit RGB for the VGA DAC, with a fixed 2-clock latency on every output.
// Four patterns (solid green, colour bars, checkerboard, gradient) are selected by a
// push-button or by auto-cycling every PATTERN_FRAMES frames; the pattern only changes
// at frame start.
//
// Ports:
//   clk               25 MHz pixel clock
//   rst_n             asynchronous active-low reset
//   h_count[15:0]     horizontal counter value (0..799 nominal)
//   v_count[15:0]     vertical counter value (0..524 nominal)
//   hsync_in          raw Hsync
//   vsync_in          raw Vsync
//   btn_next          asynchronous push-button, active high: advance pattern
//   auto_en           1 = auto-cycle patterns every PATTERN_FRAMES frames
//   Hsynq, Vsynq      hsync_in / vsync_in delayed 2 clk
//   Red/Green/Blue    4-bit colour, 0 outside the active area
//   mode[1:0]         current pattern index
//
// Build option: define VGA_PATTERN_BOX_EN to overlay a bouncing white BOX_SIZE square
// on every pattern.
module vga_pattern_gen #(
    parameter int H_ACT_START    = 144,
    parameter int H_ACT_END      = 784,
    parameter int V_ACT_START    = 35,
    parameter int V_ACT_END      = 515,
    parameter int PATTERN_FRAMES = 120,
    parameter int BOX_SIZE       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] h_count,
    input  logic [15:0] v_count,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        btn_next,
    input  logic        auto_en,
    output logic        Hsynq,
    output logic        Vsynq,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic [1:0]  mode
);

    localparam logic [15:0] H_S        = 16'(H_ACT_START);
    localparam logic [15:0] H_E        = 16'(H_ACT_END);
    localparam logic [15:0] V_S        = 16'(V_ACT_START);
    localparam logic [15:0] V_E        = 16'(V_ACT_END);
    localparam logic [15:0] FRAME_LAST = 16'(PATTERN_FRAMES - 1);

    logic frame_start;
    logic in_active;

    assign frame_start = (h_count == 16'd0) && (v_count == 16'd0);
    // Out-of-range counter values simply fail these compares and read as blanking.
    assign in_active   = (h_count >= H_S) && (h_count < H_E) &&
                         (v_count >= V_S) && (v_count < V_E);

    // Stage 1: active flag, active-area coordinates, syncs
    logic       s1_active;
    logic       s1_hs;
    logic       s1_vs;
    logic [9:0] s1_x;
    logic [9:0] s1_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_active <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_x      <= 10'd0;
            s1_y      <= 10'd0;
        end else begin
            s1_active <= in_active;
            s1_hs     <= hsync_in;
            s1_vs     <= vsync_in;
            s1_x      <= 10'(h_count - H_S);
            s1_y      <= 10'(v_count - V_S);
        end
    end

    // Button: two-flop synchroniser, then rising-edge detect
    logic btn_s1;
    logic btn_s2;
    logic btn_prev;
    logic btn_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_s1   <= btn_next;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
        end
    end

    assign btn_edge = btn_s2 & ~btn_prev;

    // Mode sequencing. An edge arriving on the frame_start cycle itself is consumed
    // there rather than parked in pending, so it cannot advance twice.
    logic [15:0] frame_cnt;
    logic        pending;
    logic        advance;

    assign advance = pending | btn_edge | (auto_en & (frame_cnt == FRAME_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode      <= 2'd0;
            frame_cnt <= 16'd0;
            pending   <= 1'b0;
        end else if (frame_start) begin
            if (advance) begin
                mode      <= mode + 2'd1;
                frame_cnt <= 16'd0;
                pending   <= 1'b0;
            end else if (auto_en) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end else if (btn_edge) begin
            pending <= 1'b1;
        end
    end

    logic box_hit;

`ifdef VGA_PATTERN_BOX_EN
    localparam logic [9:0]  BOX_X_MAX = 10'(H_ACT_END - H_ACT_START - BOX_SIZE);
    localparam logic [9:0]  BOX_Y_MAX = 10'(V_ACT_END - V_ACT_START - BOX_SIZE);
    localparam logic [10:0] BOX_W     = 11'(BOX_SIZE);

    logic [9:0] box_x;
    logic [9:0] box_y;
    logic       box_dx_neg;
    logic       box_dy_neg;

    // A bounce reverses direction and takes the step in the new direction in the same frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x      <= 10'd0;
            box_y      <= 10'd0;
            box_dx_neg <= 1'b0;
            box_dy_neg <= 1'b0;
        end else if (frame_start) begin
            if (!box_dx_neg && box_x == BOX_X_MAX) begin
                box_dx_neg <= 1'b1;
                box_x      <= box_x - 10'd1;
            end else if (box_dx_neg && box_x == 10'd0) begin
                box_dx_neg <= 1'b0;
                box_x      <= box_x + 10'd1;
            end else begin
                box_x <= box_dx_neg ? box_x - 10'd1 : box_x + 10'd1;
            end
            if (!box_dy_neg && box_y == BOX_Y_MAX) begin
                box_dy_neg <= 1'b1;
                box_y      <= box_y - 10'd1;
            end else if (box_dy_neg && box_y == 10'd0) begin
                box_dy_neg <= 1'b0;
                box_y      <= box_y + 10'd1;
            end else begin
                box_y <= box_dy_neg ? box_y - 10'd1 : box_y + 10'd1;
            end
        end
    end

    assign box_hit = (s1_x >= box_x) && ({1'b0, s1_x} < ({1'b0, box_x} + BOX_W)) &&
                     (s1_y >= box_y) && ({1'b0, s1_y} < ({1'b0, box_y} + BOX_W));
`else
    logic unused_y_bits;

    assign box_hit       = 1'b0;
    assign unused_y_bits = ^{s1_y[9], s1_y[4:0]};
`endif

    // Stage 2: colour from stage-1 coordinates and the current mode
    logic [11:0] colour;
    logic [2:0]  bar;

    always_comb begin
        colour = 12'h000;
        bar    = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (s1_x >= 10'(i * 80)) bar = 3'(i);
        end
        case (mode)
            2'd0:    colour = 12'h0F0;
            // Bar order white..black maps to R=~bar[1], G=~bar[2], B=~bar[0].
            2'd1:    colour = {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}};
            2'd2:    colour = (s1_x[5] ^ s1_y[5]) ? 12'hFFF : 12'h000;
            default: colour = {s1_x[9:6], s1_y[8:5], ~s1_x[9:6]};
        endcase
        if (box_hit) colour = 12'hFFF;
        if (!s1_active) colour = 12'h000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Hsynq <= 1'b0;
            Vsynq <= 1'b0;
            Red   <= 4'h0;
            Green <= 4'h0;
            Blue  <= 4'h0;
        end else begin
            Hsynq <= s1_hs;
            Vsynq <= s1_vs;
            Red   <= colour[11:8];
            Green <= colour[7:4];
            Blue  <= colour[3:0];
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - self-checking bench for vga_pattern_gen
`timescale 1ns/1ps
module tb_vga_pattern_gen;

    localparam int PF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] h_count = 16'd799;
    logic [15:0] v_count = 16'd524;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        btn_next = 1'b0;
    logic        auto_en = 1'b0;
    logic        Hsynq;
    logic        Vsynq;
    logic [3:0]  Red;
    logic [3:0]  Green;
    logic [3:0]  Blue;
    logic [1:0]  mode;

    vga_pattern_gen #(.PATTERN_FRAMES(PF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .h_count  (h_count),
        .v_count  (v_count),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .btn_next (btn_next),
        .auto_en  (auto_en),
        .Hsynq    (Hsynq),
        .Vsynq    (Vsynq),
        .Red      (Red),
        .Green    (Green),
        .Blue     (Blue),
        .mode     (mode)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        chk;
    } exp_t;

    exp_t        sb[$];
    string       sb_name[$];
    exp_t        cur;
    string       cur_name;
    bit          got;
    logic [11:0] act_rgb;
    logic        act_hs;
    logic        act_vs;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_mode = 0;
    int          exp_fc = 0;
    int          bx = 0;
    int          by = 0;
    int          bdx = 1;
    int          bdy = 1;

    function automatic logic [11:0] model(input int h, input int v);
        int x;
        int y;
        if (h < 144 || h >= 784 || v < 35 || v >= 515) return 12'h000;
        x = h - 144;
        y = v - 35;
`ifdef VGA_PATTERN_BOX_EN
        if (x >= bx && x < bx + 32 && y >= by && y < by + 32) return 12'hFFF;
`endif
        case (exp_mode)
            0: return 12'h0F0;
            1: begin
                case (x / 80)
                    0: return 12'hFFF;
                    1: return 12'hFF0;
                    2: return 12'h0FF;
                    3: return 12'h0F0;
                    4: return 12'hF0F;
                    5: return 12'hF00;
                    6: return 12'h00F;
                    default: return 12'h000;
                endcase
            end
            2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 12'hFFF : 12'h000;
            default: return {4'(x / 64), 4'((y / 32) % 16), 4'(15 - x / 64)};
        endcase
    endfunction

    // One pixel per clock: pops the expectation for the pixel driven two clocks ago
    // (with the outputs it produced) and pushes the expectation for the new one.
    task automatic drive(input int h, input int v, input bit chk, input string nm);
        exp_t e;
        @(negedge clk);
        got = 1'b0;
        act_rgb = {Red, Green, Blue};
        act_hs = Hsynq;
        act_vs = Vsynq;
        if (sb.size() >= 2) begin
            cur = sb.pop_front();
            cur_name = sb_name.pop_front();
            got = 1'b1;
        end
        h_count = 16'(h);
        v_count = 16'(v);
        hsync_in = (h < 96);
        vsync_in = (v < 2);
        e.rgb = model(h, v);
        e.hs = (h < 96);
        e.vs = (v < 2);
        e.chk = chk;
        sb.push_back(e);
        sb_name.push_back(nm);
    endtask

    task automatic box_step();
`ifdef VGA_PATTERN_BOX_EN
        if ((bdx > 0 && bx == 608) || (bdx < 0 && bx == 0)) bdx = -bdx;
        if ((bdy > 0 && by == 448) || (bdy < 0 && by == 0)) bdy = -bdy;
        bx += bdx;
        by += bdy;
`endif
    endtask

    task automatic box_reset();
        bx = 0;
        by = 0;
        bdx = 1;
        bdy = 1;
    endtask

    task automatic frame_pulse(input bit adv, input string nm);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(0, 0, 1'b1, {nm, "_px00"});
            else drive(799, 524, 1'b0, "idle");
            if (i == 0) begin
                if (adv) exp_mode = (exp_mode + 1) % 4;
                box_step();
            end
            if (got && cur.chk) begin
                n_cmp++;
                if ({act_rgb, act_hs, act_vs} !== {cur.rgb, cur.hs, cur.vs}) begin
                    n_err++;
                    $display("FAIL %s: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                             cur_name, act_rgb, act_hs, act_vs, cur.rgb, cur.hs, cur.vs);
                end
            end
        end
        n_cmp++;
        if (mode !== 2'(exp_mode)) begin
            n_err++;
            $display("FAIL %s_mode: mode=%0d, expected %0d", nm, mode, exp_mode);
        end
    endtask

    task automatic pulse_btn();
        btn_next = 1'b1;
        repeat (4) drive(10, 200, 1'b0, "btn_hi");
        btn_next = 1'b0;
        repeat (4) drive(10, 200, 1'b0, "btn_lo");
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({Red, Green, Blue, Hsynq, Vsynq, mode} !== 16'd0) begin
                n_err++;
                $display("FAIL reset_hold: rgb=%h hs=%b vs=%b mode=%0d, expected all 0",
                         {Red, Green, Blue}, Hsynq, Vsynq, mode);
            end
            h_count = 16'(144 + i * 50);
            v_count = 16'(i);
            hsync_in = i[0];
            vsync_in = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        sb_name.delete();
        begin
            int th[6] = '{10, 95, 96, 144, 300, 799};
            int tv[6] = '{0, 1, 2, 35, 200, 524};
            for (int i = 0; i < 8; i++) begin
                if (i < 6) drive(th[i], tv[i], 1'b1, $sformatf("reset_release_%0d", i));
                else drive(799, 524, 1'b0, "flush");
                if (got && cur.chk) begin
                    n_cmp++;
                    if ({act_rgb, act_hs, act_vs} !== {cur.rgb, cur.hs, cur.vs}) begin
                        n_err++;
                        $display("FAIL %s: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                                 cur_name, act_rgb, act_hs, act_vs, cur.rgb, cur.hs, cur.vs);
                    end
                end
            end
        end
    endtask

    task automatic test_mode0();
        int th[9] = '{144, 100, 784, 143, 783, 144, 144, 1000, 65535};
        int tv[9] = '{35, 35, 35, 35, 514, 515, 34, 40, 65535};
        for (int i = 0; i < 11; i++) begin
            if (i < 9) drive(th[i], tv[i], 1'b1, $sformatf("mode0_%0d", i));
            else drive(799, 524, 1'b0, "flush");
            if (got && cur.chk) begin
                n_cmp++;
                if ({act_rgb, act_hs, act_vs} !== {cur.rgb, cur.hs, cur.vs}) begin
                    n_err++;
                    $display("FAIL %s: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                             cur_name, act_rgb, act_hs, act_vs, cur.rgb, cur.hs, cur.vs);
                end
            end
        end
    endtask

    task automatic test_button();
        pulse_btn();
        repeat (3) drive(400, 300, 1'b0, "btn_wait");
        n_cmp++;
        if (mode !== 2'(exp_mode)) begin
            n_err++;
            $display("FAIL btn_midframe_mode: mode=%0d, expected %0d", mode, exp_mode);
        end
        frame_pulse(1'b1, "btn_adv");
        frame_pulse(1'b0, "btn_once");
    endtask

    task automatic test_bars();
        int th[7] = '{144 + 79, 144 + 80, 144 + 160, 144 + 400, 144 + 559, 144 + 560, 144 + 639};
        for (int i = 0; i < 9; i++) begin
            if (i < 7) drive(th[i], 100, 1'b1, $sformatf("bars_%0d", i));
            else drive(799, 524, 1'b0, "flush");
            if (got && cur.chk) begin
                n_cmp++;
                if ({act_rgb, act_hs, act_vs} !== {cur.rgb, cur.hs, cur.vs}) begin
                    n_err++;
                    $display("FAIL %s: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                             cur_name, act_rgb, act_hs, act_vs, cur.rgb, cur.hs, cur.vs);
                end
            end
        end
    endtask

    task automatic test_multi_press();
        repeat (3) pulse_btn();
        n_cmp++;
        if (mode !== 2'(exp_mode)) begin
            n_err++;
            $display("FAIL multi_press_midframe: mode=%0d, expected %0d", mode, exp_mode);
        end
        frame_pulse(1'b1, "multi_adv");
        frame_pulse(1'b0, "multi_once");
    endtask

    task automatic test_checker();
        int th[5] = '{144, 144 + 32, 144 + 32, 144 + 31, 144 + 639};
        int tv[5] = '{35, 35, 35 + 32, 35 + 32, 35 + 479};
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(th[i], tv[i], 1'b1, $sformatf("checker_%0d", i));
            else drive(799, 524, 1'b0, "flush");
            if (got && cur.chk) begin
                n_cmp++;
                if ({act_rgb, act_hs, act_vs} !== {cur.rgb, cur.hs, cur.vs}) begin
                    n_err++;
                    $display("FAIL %s: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                             cur_name, act_rgb, act_hs, act_vs, cur.rgb, cur.hs, cur.vs);
                end
            end
        end
    endtask

    // The button rises two clocks before frame_start, so its edge strobe lands
    // exactly on the frame_start cycle and must be consumed there.
    task automatic test_simultaneous();
        drive(799, 524, 1'b0, "idle");
        btn_next = 1'b1;
        drive(799, 524, 1'b0, "idle");
        frame_pulse(1'b1, "simul_adv");
        btn_next = 1'b0;
        frame_pulse(1'b0, "simul_once");
    endtask

    task automatic test_gradient();
        int th[4] = '{144, 144 + 639, 144 + 64, 144 + 320};
        int tv[4] = '{35, 35 + 479, 35 + 32, 35 + 250};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(th[i], tv[i], 1'b1, $sformatf("gradient_%0d", i));
            else drive(799, 524, 1'b0, "flush");
            if (got && cur.chk) begin
                n_cmp++;
                if ({act_rgb, act_hs, act_vs} !== {cur.rgb, cur.hs, cur.vs}) begin
                    n_err++;
                    $display("FAIL %s: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                             cur_name, act_rgb, act_hs, act_vs, cur.rgb, cur.hs, cur.vs);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(200 + i, 100, 1'b1, $sformatf("pre_reset_%0d", i));
            if (got && cur.chk) begin
                n_cmp++;
                if ({act_rgb, act_hs, act_vs} !== {cur.rgb, cur.hs, cur.vs}) begin
                    n_err++;
                    $display("FAIL %s: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                             cur_name, act_rgb, act_hs, act_vs, cur.rgb, cur.hs, cur.vs);
                end
            end
        end
        n_cmp++;
        if (mode !== 2'(exp_mode)) begin
            n_err++;
            $display("FAIL pre_reset_mode: mode=%0d, expected %0d", mode, exp_mode);
        end
        #5 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({Red, Green, Blue, Hsynq, Vsynq, mode} !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid_async: rgb=%h hs=%b vs=%b mode=%0d, expected all 0",
                     {Red, Green, Blue}, Hsynq, Vsynq, mode);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        sb_name.delete();
        exp_mode = 0;
        exp_fc = 0;
        box_reset();
        begin
            int th[3] = '{50, 144, 600};
            int tv[3] = '{0, 35, 300};
            for (int i = 0; i < 5; i++) begin
                if (i < 3) drive(th[i], tv[i], 1'b1, $sformatf("post_reset_%0d", i));
                else drive(799, 524, 1'b0, "flush");
                if (got && cur.chk) begin
                    n_cmp++;
                    if ({act_rgb, act_hs, act_vs} !== {cur.rgb, cur.hs, cur.vs}) begin
                        n_err++;
                        $display("FAIL %s: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                                 cur_name, act_rgb, act_hs, act_vs, cur.rgb, cur.hs, cur.vs);
                    end
                end
            end
        end
    endtask

    task automatic test_auto();
        auto_en = 1'b1;
        for (int f = 0; f < 9; f++) begin
            bit adv;
            adv = (exp_fc == PF - 1);
            if (adv) exp_fc = 0;
            else exp_fc++;
            frame_pulse(adv, $sformatf("auto_%0d", f));
        end
        auto_en = 1'b0;
        for (int f = 0; f < 3; f++) frame_pulse(1'b0, $sformatf("auto_off_%0d", f));
    endtask

    task automatic test_box();
`ifdef VGA_PATTERN_BOX_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        sb_name.delete();
        exp_mode = 0;
        exp_fc = 0;
        box_reset();
        frame_pulse(1'b0, "box_f1");
        begin
            int th[4] = '{145, 144, 176, 176};
            int tv[4] = '{36, 35, 68, 67};
            for (int i = 0; i < 6; i++) begin
                if (i < 4) drive(th[i], tv[i], 1'b1, $sformatf("box_start_%0d", i));
                else drive(799, 524, 1'b0, "flush");
                if (got && cur.chk) begin
                    n_cmp++;
                    if ({act_rgb, act_hs, act_vs} !== {cur.rgb, cur.hs, cur.vs}) begin
                        n_err++;
                        $display("FAIL %s: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                                 cur_name, act_rgb, act_hs, act_vs, cur.rgb, cur.hs, cur.vs);
                    end
                end
            end
        end
        while (bx != 608) frame_pulse(1'b0, "box_run");
        frame_pulse(1'b0, "box_bounce");
        begin
            int th[4];
            th = '{144 + bx, 144 + bx - 1, 144 + bx + 31, 144 + bx + 32};
            for (int i = 0; i < 6; i++) begin
                if (i < 4) drive(th[i], 35 + by, 1'b1, $sformatf("box_bounce_%0d", i));
                else drive(799, 524, 1'b0, "flush");
                if (got && cur.chk) begin
                    n_cmp++;
                    if ({act_rgb, act_hs, act_vs} !== {cur.rgb, cur.hs, cur.vs}) begin
                        n_err++;
                        $display("FAIL %s: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                                 cur_name, act_rgb, act_hs, act_vs, cur.rgb, cur.hs, cur.vs);
                    end
                end
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_button();
        test_bars();
        test_multi_press();
        test_checker();
        test_simultaneous();
        test_gradient();
        test_reset_mid();
        test_auto();
        test_box();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
